fpioa_eli_ctrl: RTL
===================

FPIOA_ELI_CTRL -- requirements
Module: fpioa_eli_ctrl

Interface
REQ-001 Parameter: none; the block serves exactly 4 ELI channels.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 irq_fpioa_eli  input  4  conditioned ELI request lines from the FPIOA, one per channel.
REQ-005 waddr_i  input  8  write byte address.
REQ-006 data_i  input  32  write data.
REQ-007 sel_i  input  4  byte enables; ignored, all registers are word-written.
REQ-008 we_i  input  1  write strobe.
REQ-009 raddr_i  input  8  read byte address.
REQ-010 rd_i  input  1  read strobe.
REQ-011 data_o  output  32  registered read data.
REQ-012 irq_o  output  1  registered interrupt request to the core.
REQ-013 irq_id_o  output  2  channel currently presented or serviced.

Function
REQ-014 Register map: 0x00 EN ([3:0] RW); 0x04 PEND ([3:0] RO, write-1-to-clear); 0x08 PRIO ([7:0] RW, 2 bits per channel, ch i at [2i+1:2i]); 0x0C CLAIM; 0x10 STAT (RO: [1:0]=state, [3:2]=cur_id, [4]=irq_o). Other addresses: reads return 0, writes are ignored.
REQ-015 PEND[i] is set in any cycle where irq_fpioa_eli[i]=1 and EN[i]=1; a set and a clear (W1C or claim) in the same cycle leave PEND[i]=1.
REQ-016 A channel is eligible when PEND[i]=1, EN[i]=1 and PRIO[i]!=0; the winner is the eligible channel with the highest PRIO; ties go to the lowest index.
REQ-017 FSM states: IDLE=0, ASSERT=1, SERVICE=2.
REQ-018 IDLE -> ASSERT when any channel is eligible; cur_id latches the winner on that edge.
REQ-019 ASSERT: cur_id follows the current winner every cycle, so a higher-priority arrival preempts before claim.
REQ-020 ASSERT -> IDLE when no channel remains eligible (W1C clear, EN clear or PRIO zeroed).
REQ-021 ASSERT -> SERVICE on rd_i=1 at 0x0C: PEND[cur_id] clears on that edge, and the next-cycle data_o is {1'b1, 29'b0, cur_id}.
REQ-022 A CLAIM read in IDLE or SERVICE returns 0 and has no side effect.
REQ-023 SERVICE -> IDLE on we_i=1 at 0x0C with data_i[1:0]==cur_id; a mismatched ID is ignored. A CLAIM write in other states is ignored.
REQ-024 irq_o=1 exactly in the cycles when state==ASSERT (registered: first high one cycle after eligibility appears); irq_id_o=cur_id.
REQ-025 data_o updates one cycle after rd_i=1 and holds its value otherwise; reads return register values as of before that edge's writes.
REQ-026 A simultaneous read and write to different addresses are both performed.
REQ-027 After completion, a channel that is still eligible re-enters ASSERT on the next cycle (level re-trigger).

Reset
REQ-028 On rst_n=0 (asynchronous, at any point mid-operation): state=IDLE; EN, PEND, PRIO and cur_id=0; irq_o=0; irq_id_o=0; data_o=0.
REQ-029 The first evaluation after reset release occurs at the first rising edge with rst_n=1.

Verification
REQ-030 Setup EN=0xF, PRIO=0x55; pulse ch2 -> PEND=0x4, irq_o=1 one cycle later, irq_id_o=2; CLAIM read=0x80000002; PEND=0; STAT state=2; write 2 to CLAIM -> state=0.
REQ-031 PRIO=0x1D (ch0=1, ch1=3, ch2=1); ch0 and ch2 pending -> id=0 (tie, lowest index); ch1 asserts before claim -> irq_id_o=1; CLAIM returns 0x80000001.
REQ-032 In SERVICE id=1, write 0 to CLAIM -> state stays SERVICE; write 1 -> IDLE; ch0 still pending -> irq_o=1 again the next cycle.
REQ-033 With ch3 pending in ASSERT, write 0x8 to PEND -> PEND=0, irq_o drops, state=IDLE; repeat with irq_fpioa_eli[3] held high -> PEND stays 1 and irq_o stays 1.
REQ-034 Assert rst_n=0 mid-SERVICE -> all outputs and registers are 0 immediately, without waiting for a clock edge; with EN=0 after reset, a request stays ignored.
REQ-035 A CLAIM read in IDLE returns 0x00000000; a read of 0x14 returns 0.

Source files
------------

// File: rtl/fpioa_eli_ctrl.sv
// ELI interrupt controller for four FPIOA request lines.
// Holds enable/pending/priority registers, picks the highest-priority
// eligible channel, presents it to the core and tracks the claim/complete
// handshake through a small IDLE/ASSERT/SERVICE state machine.
module fpioa_eli_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  irq_fpioa_eli,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [7:0]  raddr_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  output logic        irq_o,
  output logic [1:0]  irq_id_o
);

  localparam logic [7:0] ADDR_EN    = 8'h00;
  localparam logic [7:0] ADDR_PEND  = 8'h04;
  localparam logic [7:0] ADDR_PRIO  = 8'h08;
  localparam logic [7:0] ADDR_CLAIM = 8'h0C;
  localparam logic [7:0] ADDR_STAT  = 8'h10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [3:0]  en_q, en_d;
  logic [3:0]  pend_q, pend_d;
  logic [7:0]  prio_q, prio_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  cur_id_q, cur_id_d;
  logic        irq_q, irq_d;
  logic [31:0] data_q, data_d;

  logic [3:0]  elig;
  logic        any_elig;
  logic [1:0]  win_id;
  logic [1:0]  win_prio;
  logic        claim_rd;
  logic        complete_wr;

  // Byte enables are not used and only the low PRIO byte of write data matters.
  logic unused_bits;
  assign unused_bits = ^{sel_i, data_i[31:8]};

  // A zero priority masks a channel even if it is enabled and pending.
  assign elig     = pend_q & en_q & {|prio_q[7:6], |prio_q[5:4], |prio_q[3:2], |prio_q[1:0]};
  assign any_elig = |elig;

  // Priority arbitration: strict greater-than keeps the lowest index on ties.
  always_comb begin
    win_id   = 2'd0;
    win_prio = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (elig[i] && (prio_q[2*i +: 2] > win_prio)) begin
        win_prio = prio_q[2*i +: 2];
        win_id   = 2'(i);
      end
    end
  end

  // Claim only takes effect while a channel is actually being presented.
  assign claim_rd    = rd_i && (raddr_i == ADDR_CLAIM) && (state_q == ST_ASSERT) && any_elig;
  assign complete_wr = we_i && (waddr_i == ADDR_CLAIM) && (state_q == ST_SERVICE) &&
                       (data_i[1:0] == cur_id_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (any_elig) state_d = ST_ASSERT;
      ST_ASSERT: begin
        if (!any_elig)     state_d = ST_IDLE;
        else if (claim_rd) state_d = ST_SERVICE;
      end
      ST_SERVICE: if (complete_wr) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: presented id tracking and the registered irq level.
  always_comb begin
    cur_id_d = cur_id_q;
    if (((state_q == ST_IDLE) || (state_q == ST_ASSERT)) && any_elig && !claim_rd)
      cur_id_d = win_id;
    irq_d = (state_d == ST_ASSERT);
  end

  // Register file updates; new requests win over any same-cycle clear.
  always_comb begin
    en_d   = en_q;
    prio_d = prio_q;
    pend_d = pend_q;
    if (we_i && (waddr_i == ADDR_EN))   en_d   = data_i[3:0];
    if (we_i && (waddr_i == ADDR_PRIO)) prio_d = data_i[7:0];
    if (we_i && (waddr_i == ADDR_PEND)) pend_d = pend_d & ~data_i[3:0];
    if (claim_rd)                       pend_d[cur_id_q] = 1'b0;
    pend_d = pend_d | (irq_fpioa_eli & en_q);
  end

  // Read mux sees pre-edge register values; data_o holds when not reading.
  always_comb begin
    data_d = data_q;
    if (rd_i) begin
      case (raddr_i)
        ADDR_EN:    data_d = {28'd0, en_q};
        ADDR_PEND:  data_d = {28'd0, pend_q};
        ADDR_PRIO:  data_d = {24'd0, prio_q};
        ADDR_CLAIM: data_d = claim_rd ? {1'b1, 29'd0, cur_id_q} : 32'd0;
        ADDR_STAT:  data_d = {27'd0, irq_q, cur_id_q, state_q};
        default:    data_d = 32'd0;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 4'd0;
      pend_q   <= 4'd0;
      prio_q   <= 8'd0;
      cur_id_q <= 2'd0;
      irq_q    <= 1'b0;
      data_q   <= 32'd0;
    end else begin
      en_q     <= en_d;
      pend_q   <= pend_d;
      prio_q   <= prio_d;
      cur_id_q <= cur_id_d;
      irq_q    <= irq_d;
      data_q   <= data_d;
    end
  end

  assign data_o   = data_q;
  assign irq_o    = irq_q;
  assign irq_id_o = cur_id_q;

endmodule
